// File: rtl/lcd_char_driver.sv
// HD44780-compatible character-LCD driver: power-up wait, 8-bit init sequence, then
// one DDRAM set-address command plus one data byte per client write request.
module lcd_char_driver #(
  parameter int unsigned T_POWERUP = 750_000,
  parameter int unsigned T_EN      = 25,
  parameter int unsigned T_CMD     = 2_500,
  parameter int unsigned T_CLEAR   = 100_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       lcd_req,
  input  logic [1:0] lcd_row,
  input  logic [3:0] lcd_col,
  input  logic [7:0] lcd_char,
  output logic       lcd_busy,
  output logic       lcd_done,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_data,
  output logic       init_done
);

  typedef enum logic [2:0] {PWR_WAIT, INIT, IDLE, WRITE, DONE} state_t;
  typedef enum logic [1:0] {PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  // Counters compare against parameter-1, so a parameter of 1 lasts exactly one cycle.
  localparam logic [31:0] PWR_LAST   = 32'(T_POWERUP - 1);
  localparam logic [31:0] EN_LAST    = 32'(T_EN - 1);
  localparam logic [31:0] CMD_LAST   = 32'(T_CMD - 1);
  localparam logic [31:0] CLEAR_LAST = 32'(T_CLEAR - 1);
  localparam logic [2:0]  INIT_LAST  = 3'd5;
  localparam logic [2:0]  WRITE_LAST = 3'd1;

  state_t      state_q, state_d;
  phase_t      phase_q, phase_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [1:0]  row_q, row_d;
  logic [3:0]  col_q, col_d;
  logic [7:0]  char_q, char_d;
  logic        init_done_q, init_done_d;

  logic        byte_rs;
  logic [7:0]  byte_data;
  logic [31:0] phase_last;
  logic        phase_end;
  logic        engine_active;

  function automatic logic [7:0] init_byte(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_byte = 8'h38;
      3'd3:             init_byte = 8'h0C;
      3'd4:             init_byte = 8'h01;
      default:          init_byte = 8'h06;
    endcase
  endfunction

  // Rows 2/3 of a 16x4 panel continue rows 0/1 at DDRAM offset 0x10.
  function automatic logic [7:0] row_base(input logic [1:0] row);
    case (row)
      2'd0:    row_base = 8'h80;
      2'd1:    row_base = 8'hC0;
      2'd2:    row_base = 8'h90;
      default: row_base = 8'hD0;
    endcase
  endfunction

  assign engine_active = (state_q == INIT) || (state_q == WRITE);

  // The byte on the bus is a pure function of state and index, so it cannot
  // change while the engine walks through SETUP, PULSE and WAIT.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch is inferred.
    byte_rs   = 1'b0;
    byte_data = 8'h00;
    case (state_q)
      INIT: byte_data = init_byte(idx_q);
      WRITE: begin
        if (idx_q == 3'd0) begin
          byte_data = row_base(row_q) | {4'b0, col_q};
        end else begin
          byte_rs   = 1'b1;
          byte_data = char_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    phase_last = 32'd0;
    case (phase_q)
      PH_PULSE: phase_last = EN_LAST;
      PH_WAIT:  phase_last = (!byte_rs && byte_data == 8'h01) ? CLEAR_LAST : CMD_LAST;
      default:  phase_last = 32'd0;
    endcase
  end

  assign phase_end = (cnt_q == phase_last);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    row_d       = row_q;
    col_d       = col_q;
    char_d      = char_q;
    init_done_d = init_done_q;

    case (state_q)
      PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          cnt_d   = 32'd0;
          idx_d   = 3'd0;
          phase_d = PH_SETUP;
          state_d = INIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      INIT, WRITE: begin
        if (!phase_end) begin
          cnt_d = cnt_q + 32'd1;
        end else begin
          cnt_d = 32'd0;
          case (phase_q)
            PH_SETUP: phase_d = PH_PULSE;
            PH_PULSE: phase_d = PH_WAIT;
            default: begin
              phase_d = PH_SETUP;
              if (state_q == INIT && idx_q == INIT_LAST) begin
                idx_d       = 3'd0;
                init_done_d = 1'b1;
                state_d     = IDLE;
              end else if (state_q == WRITE && idx_q == WRITE_LAST) begin
                idx_d   = 3'd0;
                state_d = DONE;
              end else begin
                idx_d = idx_q + 3'd1;
              end
            end
          endcase
        end
      end

      IDLE: begin
        if (lcd_req) begin
          row_d   = lcd_row;
          col_d   = lcd_col;
          char_d  = lcd_char;
          cnt_d   = 32'd0;
          idx_d   = 3'd0;
          phase_d = PH_SETUP;
          state_d = WRITE;
        end
      end

      // DONE lasts one busy cycle so a client dropping req on the done edge
      // is never seen as a fresh request.
      DONE:    state_d = IDLE;
      default: state_d = PWR_WAIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= PWR_WAIT;
      phase_q     <= PH_SETUP;
      cnt_q       <= '0;
      idx_q       <= '0;
      row_q       <= '0;
      col_q       <= '0;
      char_q      <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      row_q       <= row_d;
      col_q       <= col_d;
      char_q      <= char_d;
      init_done_q <= init_done_d;
    end
  end

  assign lcd_busy  = (state_q != IDLE);
  assign lcd_done  = (state_q == DONE);
  assign lcd_e     = engine_active && (phase_q == PH_PULSE);
  assign lcd_rs    = byte_rs;
  assign lcd_data  = byte_data;
  assign lcd_rw    = 1'b0;
  assign init_done = init_done_q;

endmodule

// File: tb/tb_lcd_char_driver.sv
// Scoreboard bench for lcd_char_driver: stimulus queues expected enable pulses and
// done pulses; a negedge monitor pops and compares them as the DUT produces them.
`timescale 1ns/1ps
module tb_lcd_char_driver;

  localparam int T_POWERUP = 10;
  localparam int T_EN      = 2;
  localparam int T_CMD     = 4;
  localparam int T_CLEAR   = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       lcd_req = 1'b0;
  logic [1:0] lcd_row = '0;
  logic [3:0] lcd_col = '0;
  logic [7:0] lcd_char = '0;
  logic       lcd_busy, lcd_done, lcd_e, lcd_rs, lcd_rw, init_done;
  logic [7:0] lcd_data;

  always #5 clk = ~clk;

  lcd_char_driver #(
    .T_POWERUP(T_POWERUP),
    .T_EN     (T_EN),
    .T_CMD    (T_CMD),
    .T_CLEAR  (T_CLEAR)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .lcd_req  (lcd_req),
    .lcd_row  (lcd_row),
    .lcd_col  (lcd_col),
    .lcd_char (lcd_char),
    .lcd_busy (lcd_busy),
    .lcd_done (lcd_done),
    .lcd_e    (lcd_e),
    .lcd_rs   (lcd_rs),
    .lcd_rw   (lcd_rw),
    .lcd_data (lcd_data),
    .init_done(init_done)
  );

  typedef struct {
    bit         is_done;
    bit         rs;
    logic [7:0] data;
    int         cyc;
  } ev_t;

  ev_t sb[$];
  int  n_vec  = 0;
  int  n_miss = 0;
  int  n_e    = 0;
  int  n_done = 0;
  int  cyc;

  // Init bytes and the cycle each enable pulse starts, worked out by hand.
  logic [7:0] init_seq   [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  int         init_start [6] = '{11, 18, 25, 32, 39, 50};

  // At a negedge, cyc holds the spec cycle number of the current clock period.
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  logic       mon_en = 1'b0;
  logic       e_prev = 1'b0;
  logic       prev_rs = 1'b0;
  logic [7:0] prev_data = '0;
  logic       p_rs;
  logic [7:0] p_data;
  int         p_start, p_width;
  bit         p_stable;

  task automatic score_pulse();
    ev_t ex;
    check("pulse_expected", 32'(sb.size() > 0), 1);
    if (sb.size() == 0) return;
    ex = sb.pop_front();
    check("pulse_kind", 32'(ex.is_done), 0);
    check("pulse_rs_data", {23'b0, p_rs, p_data}, {23'b0, ex.rs, ex.data});
    check("pulse_width", p_width, T_EN);
    check("pulse_bus_stable", 32'(p_stable), 1);
    check("pulse_start_cycle", p_start, ex.cyc);
  endtask

  task automatic score_done();
    ev_t ex;
    check("done_expected", 32'(sb.size() > 0), 1);
    if (sb.size() == 0) return;
    ex = sb.pop_front();
    check("done_kind", 32'(ex.is_done), 1);
    check("done_cycle", cyc, ex.cyc);
    check("busy_during_done", lcd_busy, 1);
  endtask

  always @(negedge clk) begin
    if (!rst_n || !mon_en) begin
      e_prev = 1'b0;
    end else begin
      if (lcd_e && !e_prev) begin
        p_start  = cyc;
        p_width  = 1;
        p_rs     = lcd_rs;
        p_data   = lcd_data;
        p_stable = (prev_rs === lcd_rs) && (prev_data === lcd_data);
      end else if (lcd_e) begin
        p_width++;
        if (lcd_rs !== p_rs || lcd_data !== p_data) p_stable = 0;
      end else if (e_prev) begin
        if (lcd_rs !== p_rs || lcd_data !== p_data) p_stable = 0;
        n_e++;
        score_pulse();
      end
      if (lcd_done) begin
        n_done++;
        score_done();
      end
      e_prev = lcd_e;
    end
    prev_rs   = lcd_rs;
    prev_data = lcd_data;
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_pulse(input bit rs, input logic [7:0] data, input int start);
    ev_t ev;
    ev.is_done = 0; ev.rs = rs; ev.data = data; ev.cyc = start;
    sb.push_back(ev);
  endtask

  task automatic push_done(input int at);
    ev_t ev;
    ev.is_done = 1; ev.rs = 0; ev.data = 8'h00; ev.cyc = at;
    sb.push_back(ev);
  endtask

  // A write accepted at cycle a: address pulse at a+2, data pulse at a+9, done at a+15.
  task automatic push_write(input logic [7:0] addr, input logic [7:0] ch, input int a);
    push_pulse(1'b0, addr, a + 2);
    push_pulse(1'b1, ch, a + 9);
    push_done(a + 15);
  endtask

  task automatic do_reset(input bit hold, input logic [1:0] r, input logic [3:0] c,
                          input logic [7:0] ch);
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    lcd_req  = hold;
    lcd_row  = r;
    lcd_col  = c;
    lcd_char = ch;
    sb.delete();
    repeat (2) @(negedge clk);
    check("rst_busy", lcd_busy, 1);
    check("rst_done", lcd_done, 0);
    check("rst_e", lcd_e, 0);
    check("rst_rs", lcd_rs, 0);
    check("rst_rw", lcd_rw, 0);
    check("rst_data", lcd_data, 8'h00);
    check("rst_init_done", init_done, 0);
    for (int k = 0; k < 6; k++) push_pulse(1'b0, init_seq[k], init_start[k]);
    rst_n  = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic wait_init_end();
    for (int i = 0; i < 200 && cyc != 55; i++) @(negedge clk);
    check("reach_cycle_55", cyc, 55);
    check("busy_c55", lcd_busy, 1);
    check("init_done_c55", init_done, 0);
    @(negedge clk);
    check("busy_c56", lcd_busy, 0);
    check("init_done_c56", init_done, 1);
  endtask

  task automatic wait_idle(input int max_cycles);
    for (int i = 0; i < max_cycles && lcd_busy; i++) @(negedge clk);
    check("idle_timeout", lcd_busy, 0);
  endtask

  task automatic wait_done(input int max_cycles);
    for (int i = 0; i < max_cycles && !lcd_done; i++) @(negedge clk);
    check("done_timeout", lcd_done, 1);
  endtask

  task automatic client_write(input logic [1:0] r, input logic [3:0] c, input logic [7:0] ch,
                              input logic [7:0] exp_addr, input bit drop_early);
    int a;
    wait_idle(100);
    a        = cyc;
    lcd_req  = 1'b1;
    lcd_row  = r;
    lcd_col  = c;
    lcd_char = ch;
    push_write(exp_addr, ch, a);
    @(negedge clk);
    check("busy_after_accept", lcd_busy, 1);
    lcd_row  = ~r;
    lcd_col  = ~c;
    lcd_char = ~ch;
    if (drop_early) lcd_req = 1'b0;
    wait_done(40);
    lcd_req = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int d0, e0;

    // Init with no requests.
    do_reset(1'b0, 2'd0, 4'd0, 8'h00);
    wait_init_end();
    check("rw_tied_low", lcd_rw, 0);

    // Single write: row 1, col 5, 'D'.
    client_write(2'd1, 4'd5, 8'h44, 8'hC5, 1'b0);
    @(negedge clk);
    check("single_busy_after", lcd_busy, 0);
    check("single_done_one_cycle", lcd_done, 0);

    // 16 back-to-back client writes on row 0.
    d0 = n_done;
    e0 = n_e;
    for (int c = 0; c < 16; c++)
      client_write(2'd0, 4'(c), 8'h30 + 8'(c), 8'h80 + 8'(c), 1'b0);
    repeat (5) @(negedge clk);
    check("b2b_done_count", n_done - d0, 16);
    check("b2b_e_count", n_e - e0, 32);

    // Request dropped one cycle after accept.
    d0 = n_done;
    client_write(2'd3, 4'd0, 8'h41, 8'hD0, 1'b1);
    repeat (20) @(negedge clk);
    check("early_drop_idle", lcd_busy, 0);
    check("early_drop_done_count", n_done - d0, 1);

    // Request held through reset and init: accepted at cycle 56.
    do_reset(1'b1, 2'd2, 4'd15, 8'h21);
    push_write(8'h9F, 8'h21, 56);
    wait_init_end();
    @(negedge clk);
    check("held_busy_c57", lcd_busy, 1);
    wait_done(40);
    lcd_req = 1'b0;

    // Async reset while lcd_e is high, then a full init again.
    repeat (2) @(negedge clk);
    mon_en = 1'b0;
    wait_idle(20);
    lcd_req  = 1'b1;
    lcd_row  = 2'd1;
    lcd_col  = 4'd0;
    lcd_char = 8'h55;
    for (int i = 0; i < 20 && !lcd_e; i++) @(negedge clk);
    check("mid_e_seen", lcd_e, 1);
    lcd_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_e", lcd_e, 0);
    check("async_rst_init_done", init_done, 0);
    check("async_rst_done", lcd_done, 0);
    check("async_rst_busy", lcd_busy, 1);
    do_reset(1'b0, 2'd0, 4'd0, 8'h00);
    wait_init_end();

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
